byte_piso_serializer: RTL and testbench
=======================================

// Module: byte_piso_serializer
//
// PURPOSE
// Parallel-in/serial-out reader for the 8-bit D latch bank. Captures a
// WIDTH-bit word on a load request, shifts it out one bit per clock with a
// valid strobe, then pulses done. Sits between the latch bank's q outputs and
// any single-wire consumer; the consumer never sees a partial word.
//
// PARAMETERS
// WIDTH      8   word width in bits; legal range 2..32
// MSB_FIRST  1   1: shift out bit WIDTH-1 first; 0: shift out bit 0 first
//
// PORTS
// clk         in   1      clock; all state updates on rising edge
// reset       in   1      synchronous, active-high reset
// d           in   WIDTH  parallel word, sampled only on an accepted load
// load        in   1      load request; accepted only when ready=1
// ready       out  1      1 in IDLE only; load is accepted this cycle
// sout        out  1      serial data bit; 0 whenever sout_valid=0
// sout_valid  out  1      1 for exactly WIDTH consecutive cycles per word
// done        out  1      one-cycle pulse after the last bit of a word
//
// BEHAVIOUR
// - All outputs registered or decoded from registered state; no combinational
//   path from d/load to any output.
// - Reset (sync, priority over everything): state=IDLE, shreg=0, cnt=0;
//   ready=1, sout=0, sout_valid=0, done=0 from the cycle after the edge.
// - States: IDLE, SHIFT, DONE. cnt is $clog2(WIDTH) bits.
// - IDLE: ready=1. Edge with load=1: shreg<=d, cnt<=0, go SHIFT.
//   load=0: stay IDLE.
// - SHIFT: ready=0, sout_valid=1, sout=shreg[WIDTH-1] (MSB_FIRST=1) or
//   shreg[0] (MSB_FIRST=0). Each edge: shift toward the output end, fill 0,
//   cnt<=cnt+1. Edge with cnt==WIDTH-1: go DONE (no wrap; cnt reset on load).
// - DONE: exactly one cycle; done=1, sout_valid=0, sout=0, ready=0; then IDLE.
// - Latency: first bit visible in the cycle after the accepting edge; done
//   visible WIDTH+1 cycles after it. Minimum word period = WIDTH+2 cycles.
// - load while ready=0: ignored, d not sampled, in-flight word unchanged.
// - reset during SHIFT or DONE: word aborted, done not pulsed, IDLE next.
// - reset and load on the same edge: reset wins; load is not accepted.
// - d changes during SHIFT: no effect on the stream.
//
// TESTING
// 1. reset=1 for 2 edges, load=0 -> ready=1, sout=0, sout_valid=0, done=0.
// 2. MSB_FIRST=1, load 8'b10110010 -> sout 1,0,1,1,0,0,1,0 on 8 consecutive
//    valid cycles; done=1 on cycle 9; ready=1 on cycle 10.
// 3. MSB_FIRST=0, load 8'h01 -> sout 1,0,0,0,0,0,0,0; done after 8th bit.
// 4. load 8'hA5, then load=1 with d=8'hFF on every SHIFT cycle -> stream
//    still 1,0,1,0,0,1,0,1; 8'hFF never appears.
// 5. load 8'hFF, reset=1 at 4th valid bit -> sout_valid=0, ready=1 next
//    cycle; done stays 0 for 12 following cycles.
// 6. load held 1, d=8'hA5 then 8'h3C -> two complete frames, second frame's
//    first bit exactly 10 cycles after the first frame's first bit.

Source files
------------

// File: rtl/byte_piso_serializer.sv
// Parallel-in/serial-out reader for the D latch bank: captures a WIDTH-bit word
// on an accepted load, streams it one bit per clock, then pulses done.
module byte_piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] shreg;
  logic [CntW-1:0]  cnt;

  logic [WIDTH-1:0] shreg_shifted;
  logic             load_bit;
  logic             shifted_bit;

  // Shift toward the output end, filling with zero.
  always_comb begin
    shreg_shifted = '0;
    load_bit      = 1'b0;
    shifted_bit   = 1'b0;
    if (MSB_FIRST) begin
      shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
      load_bit      = d[WIDTH-1];
      shifted_bit   = shreg_shifted[WIDTH-1];
    end else begin
      shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
      load_bit      = d[0];
      shifted_bit   = shreg_shifted[0];
    end
  end

  // Outputs are registered alongside the state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      shreg      <= '0;
      cnt        <= '0;
      ready      <= 1'b1;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (load) begin
            state      <= StShift;
            shreg      <= d;
            cnt        <= '0;
            ready      <= 1'b0;
            sout       <= load_bit;
            sout_valid <= 1'b1;
          end
        end
        StShift: begin
          shreg <= shreg_shifted;
          cnt   <= cnt + 1'b1;
          if (cnt == CntLast) begin
            state      <= StDone;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b1;
          end else begin
            sout <= shifted_bit;
          end
        end
        StDone: begin
          state <= StIdle;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state      <= StIdle;
          shreg      <= '0;
          cnt        <= '0;
          ready      <= 1'b1;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_piso_serializer.sv
// Bench for byte_piso_serializer: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a queue-based timeline model.
module tb_byte_piso_serializer;

  localparam int unsigned W = 8;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         load  = 1'b0;
  logic [W-1:0] d     = '0;

  logic m_ready, m_sout, m_valid, m_done;
  logic l_ready, l_sout, l_valid, l_done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  bit          armed    = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  byte_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .load       (load),
    .ready      (m_ready),
    .sout       (m_sout),
    .sout_valid (m_valid),
    .done       (m_done)
  );

  byte_piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .load       (load),
    .ready      (l_ready),
    .sout       (l_sout),
    .sout_valid (l_valid),
    .done       (l_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a queue of expected {ready, valid, done, sout} per future cycle.
  // Empty queue means idle; a load is accepted only when idle.
  logic [3:0] mq[$];
  logic [3:0] lq[$];

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      lq.delete();
      armed = 1'b1;
    end else if (mq.size() == 0) begin
      if (load) begin
        for (int i = 0; i < W; i++) begin
          mq.push_back({3'b010, d[W-1-i]});
          lq.push_back({3'b010, d[i]});
        end
        mq.push_back(4'b0010);
        lq.push_back(4'b0010);
      end
    end else begin
      void'(mq.pop_front());
      void'(lq.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [3:0] em, el;
    if (armed) begin
      em = (mq.size() == 0) ? 4'b1000 : mq[0];
      el = (lq.size() == 0) ? 4'b1000 : lq[0];
      check("msb_ready", 32'(m_ready), 32'(em[3]));
      check("msb_valid", 32'(m_valid), 32'(em[2]));
      check("msb_done",  32'(m_done),  32'(em[1]));
      check("msb_sout",  32'(m_sout),  32'(em[0]));
      check("lsb_ready", 32'(l_ready), 32'(el[3]));
      check("lsb_valid", 32'(l_valid), 32'(el[2]));
      check("lsb_done",  32'(l_done),  32'(el[1]));
      check("lsb_sout",  32'(l_sout),  32'(el[0]));
    end
  end

  // Stream capture: completed frames, first-bit cycles and done pulses.
  logic [W-1:0] m_cap = '0;
  logic [W-1:0] l_cap = '0;
  logic         m_prev_valid = 1'b0;
  logic [W-1:0] m_frames[$];
  logic [W-1:0] l_frames[$];
  int unsigned  first_cyc[$];
  int unsigned  done_cyc = 0;
  int unsigned  done_cnt = 0;

  always @(negedge clk) begin
    if (m_valid === 1'b1) begin
      m_cap = {m_cap[W-2:0], m_sout};
      if (m_prev_valid !== 1'b1) first_cyc.push_back(cyc);
    end
    if (l_valid === 1'b1) l_cap = {l_cap[W-2:0], l_sout};
    if (m_done === 1'b1) begin
      m_frames.push_back(m_cap);
      l_frames.push_back(l_cap);
      done_cyc = cyc;
      done_cnt++;
    end
    m_prev_valid = m_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int unsigned nf, fc, dc;

    // 1: reset for two edges
    reset = 1'b1;
    load  = 1'b0;
    tick(2);
    check("rst_ready", 32'(m_ready), 32'd1);
    check("rst_sout",  32'(m_sout),  32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_done",  32'(m_done),  32'd0);
    reset = 1'b0;
    tick(2);

    // 2: 8'b10110010
    d = 8'b1011_0010;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(12);
    check("t2_msb_stream", 32'(m_frames[$]), 32'h B2);
    check("t2_lsb_stream", 32'(l_frames[$]), 32'h 4D);
    check("t2_done_lat", done_cyc - first_cyc[$], 32'd8);

    // 3: 8'h01
    d = 8'h01;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(12);
    check("t3_lsb_stream", 32'(l_frames[$]), 32'h80);
    check("t3_msb_stream", 32'(m_frames[$]), 32'h01);
    check("t3_done_lat", done_cyc - first_cyc[$], 32'd8);

    // 4: load stays high with d=FF while busy
    nf = m_frames.size();
    d = 8'hA5;
    load = 1'b1;
    tick(1);
    d = 8'hFF;
    tick(9);
    load = 1'b0;
    tick(4);
    check("t4_frames", m_frames.size(), nf + 1);
    check("t4_msb_stream", 32'(m_frames[$]), 32'hA5);
    check("t4_lsb_stream", 32'(l_frames[$]), 32'hA5);

    // 5: reset on the 4th valid bit aborts the word
    nf = m_frames.size();
    d = 8'hFF;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t5_valid", 32'(m_valid), 32'd0);
    check("t5_ready", 32'(m_ready), 32'd1);
    dc = done_cnt;
    tick(12);
    check("t5_no_done", done_cnt, dc);
    check("t5_frames", m_frames.size(), nf);

    // 6: load held high, back-to-back frames
    nf = m_frames.size();
    fc = first_cyc.size();
    d = 8'hA5;
    load = 1'b1;
    tick(1);
    d = 8'h3C;
    tick(10);
    load = 1'b0;
    tick(12);
    check("t6_frames", m_frames.size(), nf + 2);
    check("t6_first", 32'(m_frames[$-1]), 32'hA5);
    check("t6_second", 32'(m_frames[$]), 32'h3C);
    check("t6_lsb_second", 32'(l_frames[$]), 32'h3C);
    check("t6_period", first_cyc[fc+1] - first_cyc[fc], 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
